beep_note_seq: RTL and testbench

//  Upstream score sequencer for the buzzer tone stage. Buffers {pitch, duration} note

---
 rtl/beep_note_seq.sv | 136 +++++++++++++
 tb/tb_beep_note_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/beep_note_seq.sv
// beep_note_seq: FIFO-buffered {pitch, duration} player that drives the buzzer tone stage.
// Define TEMPO_SCALE_EN to add a tempo[1:0] input that shortens the beat of each note.
module beep_note_seq #(
    parameter int CLK_PRE    = 50_000_000,
    parameter int BEAT_CYC   = 15_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int PER_W      = 17
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [3:0]                    in_pitch,
    input  logic [2:0]                    in_dur,
    input  logic                          play_en,
`ifdef TEMPO_SCALE_EN
    input  logic [1:0]                    tempo,
`endif
    output logic [PER_W-1:0]              tone_period,
    output logic                          tone_gate,
    output logic                          note_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BEAT_CYC + 1);

    function automatic int base_hz(input int n);
        return n == 0 ? 523 : n == 1 ? 587 : n == 2 ? 659 : n == 3 ? 698 :
               n == 4 ? 784 : n == 5 ? 880 : 988;
    endfunction

    // Periods for all 16 pitch codes, folded to constants at elaboration.
    function automatic logic [16*PER_W-1:0] build_tab();
        logic [16*PER_W-1:0] t;
        t = '0;
        for (int i = 0; i < 16; i++)
            t[i*PER_W +: PER_W] = (i == 0 || i == 15) ? PER_W'(1) :
                PER_W'(CLK_PRE / (i < 8 ? base_hz(i - 1) : 2 * base_hz(i - 8)));
        return t;
    endfunction

    localparam logic [16*PER_W-1:0] PER_TAB = build_tab();

    typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;

    state_t          state, state_nxt;
    logic [6:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     level_nxt;
    logic            push, pop, last_beat, beat_end, gate_d;
    logic [CW-1:0]   beat_cnt, beat_len;
    logic [2:0]      beat_idx, cur_dur;
    logic [3:0]      cur_pitch;

`ifdef TEMPO_SCALE_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            beat_len <= CW'(BEAT_CYC);
        else if (state == LOAD)
            beat_len <= CW'(BEAT_CYC) >> tempo;
`else
    assign beat_len = CW'(BEAT_CYC);
`endif

    assign push      = in_valid && in_ready;
    assign last_beat = beat_idx == cur_dur;
    assign beat_end  = beat_cnt == beat_len - CW'(1);
    assign level_nxt = fifo_level + (AW+1)'(push) - (AW+1)'(pop);
    // Silence the tail of the last beat so repeated notes are heard as separate.
    assign gate_d    = state == PLAY && cur_pitch != 4'd0 && cur_pitch != 4'd15 &&
                       !(last_beat && beat_cnt >= beat_len - (beat_len >> 3));

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: if (play_en && fifo_level != '0) begin
                pop       = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: state_nxt = PLAY;
            PLAY: if (beat_end && last_beat) begin
                pop       = play_en && fifo_level != '0;
                state_nxt = pop ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (push)
            mem[wr_ptr] <= {in_pitch, in_dur};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
        end else begin
            wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
            fifo_level <= level_nxt;
            in_ready   <= level_nxt != (AW+1)'(FIFO_DEPTH);
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            cur_pitch <= '0;
            cur_dur   <= '0;
            beat_cnt  <= '0;
            beat_idx  <= '0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= (state != PLAY || beat_end) ? '0 : beat_cnt + CW'(1);
            beat_idx <= state != PLAY ? '0 : beat_end ? beat_idx + 3'd1 : beat_idx;
            if (pop)
                {cur_pitch, cur_dur} <= mem[rd_ptr];
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            tone_period <= PER_W'(1);
            tone_gate   <= 1'b0;
            note_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            note_start <= state == LOAD;
            busy       <= state != IDLE;
            tone_gate  <= gate_d;
            if (state == LOAD)
                tone_period <= PER_TAB[cur_pitch*PER_W +: PER_W];
        end
endmodule

// File: tb/tb_beep_note_seq.sv
// tb_beep_note_seq: directed checks of beep_note_seq with an 80-cycle beat.
module tb_beep_note_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_pitch = '0;
    logic [2:0]  in_dur = '0;
    logic        play_en = 1'b0;
    logic [16:0] tone_period;
    logic        tone_gate, note_start, busy;
    logic [4:0]  fifo_level;
`ifdef TEMPO_SCALE_EN
    logic [1:0]  tempo = 2'd0;
`endif
    int checks = 0;
    int errors = 0;
    int per_tab [16] = '{1, 95602, 85178, 75872, 71633, 63775, 56818, 50607,
                         47801, 42589, 37936, 35816, 31887, 28409, 25303, 1};

    beep_note_seq #(.CLK_PRE(50_000_000), .BEAT_CYC(80), .FIFO_DEPTH(16), .PER_W(17)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pitch(in_pitch), .in_dur(in_dur), .play_en(play_en),
`ifdef TEMPO_SCALE_EN
        .tempo(tempo),
`endif
        .tone_period(tone_period), .tone_gate(tone_gate), .note_start(note_start),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] p, input logic [2:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_pitch = p;
        in_dur   = d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expects the LOAD output cycle on the next negedge, then len PLAY cycles.
    task automatic play_note(input string tag, input int per, input int len, input int cut,
                             input bit rest, input int drop_at);
        int bad = 0;
        @(negedge clk);
        check({tag, "_start"}, note_start, 1);
        check({tag, "_per"}, tone_period, per);
        check({tag, "_load_gate"}, tone_gate, 0);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == drop_at) play_en = 1'b0;
            if (tone_gate !== (!rest && i < len - cut)) bad++;
            if (note_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        check({tag, "_gate"}, bad, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_per", tone_period, 1);
        check("rst_gate", tone_gate, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", in_ready, 1);
        check("rst_level", fifo_level, 0);

        play_en = 1'b1;
        push(4'd1, 3'd0);
        check("t2_level", fifo_level, 1);
        @(negedge clk);
        check("t2_lat", note_start, 0);
        play_note("t2", 95602, 80, 10, 0, -1);
        @(negedge clk);
        check("t2_busy_end", busy, 0);

        @(negedge clk);
        in_valid = 1'b1; in_pitch = 4'd8; in_dur = 3'd1;
        @(negedge clk);
        in_pitch = 4'd0; in_dur = 3'd0;
        @(negedge clk);
        in_valid = 1'b0;
        check("t3_lat", note_start, 0);
        play_note("t3_oct", 47801, 160, 10, 0, -1);
        play_note("t3_rest", 1, 80, 10, 1, -1);
        @(negedge clk);
        check("t3_busy_end", busy, 0);

        play_en = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            if (i == 16) check("t4_ready_full", in_ready, 0);
            in_valid = 1'b1;
            in_pitch = 4'(i);
            in_dur   = 3'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("t4_level", fifo_level, 16);
        check("t4_ready", in_ready, 0);
        check("t4_idle", busy, 0);
        play_en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 16; i++)
            play_note($sformatf("t4_n%0d", i), per_tab[i], 80, 10, i == 0 || i == 15, -1);
        @(negedge clk);
        check("t4_busy_end", busy, 0);
        check("t4_level_end", fifo_level, 0);

        @(negedge clk);
        in_valid = 1'b1; in_pitch = 4'd3; in_dur = 3'd0;
        @(negedge clk);
        in_pitch = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        play_note("t5_n1", 75872, 80, 10, 0, 30);
        @(negedge clk);
        check("t5_busy_drop", busy, 0);
        check("t5_level_kept", fifo_level, 1);
        repeat (3) @(negedge clk);
        check("t5_held", busy | note_start, 0);
        play_en = 1'b1;
        @(negedge clk);
        check("t5_lat", note_start, 0);
        play_note("t5_n2", 56818, 80, 10, 0, -1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pitch = 4'(i + 2);
            in_dur   = 3'd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_busy_pre", busy, 1);
        check("t6_level_pre", fifo_level, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_per", tone_period, 1);
        check("t6_rst_gate", tone_gate, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_ready", in_ready, 1);
        check("t6_rst_level", fifo_level, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_level_post", fifo_level, 0);
        check("t6_busy_post", busy | note_start, 0);

`ifdef TEMPO_SCALE_EN
        tempo = 2'd2;
        push(4'd5, 3'd0);
        @(negedge clk);
        play_note("t7", 63775, 20, 2, 0, -1);
        @(negedge clk);
        check("t7_busy_end", busy, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
